// File: rtl/ccsds123_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : ccsds123_out_buffer
//  Purpose  : Captures the valid-only compressed-output bus of ccsds123_top
//             into a first-word-fall-through FIFO and re-emits it as an
//             AXI-Stream master with backpressure. Also provides an
//             almost-full throttle, a sticky overflow flag and per-frame
//             word accounting.
//  Ports    :
//    clk          clock, rising edge
//    aresetn      asynchronous active-low reset
//    in_tdata     word from the core output bus
//    in_tvalid    word valid (no ready: captured or dropped)
//    in_tlast     last word of the compressed image
//    out_tdata    AXI-Stream data (entry at read pointer)
//    out_tvalid   AXI-Stream valid (FIFO not empty)
//    out_tready   AXI-Stream ready
//    out_tlast    AXI-Stream last
//    almost_full  occupancy >= DEPTH-HEADROOM (after the current edge)
//    overflow     sticky: an input word was dropped
//    frame_done   one-cycle pulse after the tlast word left the output
//    frame_words  word count of the frame just completed
//  Revision : 1.0  initial release
// ============================================================================
module ccsds123_out_buffer #(
  parameter int BUS_WIDTH = 64,
  parameter int ADDR_W    = 4,
  parameter int HEADROOM  = 4,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 aresetn,
  input  logic [BUS_WIDTH-1:0] in_tdata,
  input  logic                 in_tvalid,
  input  logic                 in_tlast,
  output logic [BUS_WIDTH-1:0] out_tdata,
  output logic                 out_tvalid,
  input  logic                 out_tready,
  output logic                 out_tlast,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 frame_done,
  output logic [CNT_W-1:0]     frame_words
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam int              AF_LVL   = DEPTH - HEADROOM;
  localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_LVL_C = AF_LVL[ADDR_W:0];

  // Storage: each entry is {tlast, tdata}
  logic [BUS_WIDTH:0]   mem_q [DEPTH];

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]      count_q,  count_d;
  logic                 af_q,     af_d;
  logic                 ovf_q,    ovf_d;
  logic                 fd_q,     fd_d;
  logic [CNT_W-1:0]     fw_q,     fw_d;
  logic [CNT_W-1:0]     wcnt_q,   wcnt_d;

  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [BUS_WIDTH:0]   head;

  assign head       = mem_q[rd_ptr_q];
  assign out_tvalid = (count_q != '0);
  assign out_tdata  = head[BUS_WIDTH-1:0];
  assign out_tlast  = head[BUS_WIDTH];

  assign pop  = out_tvalid & out_tready;
  // A full FIFO still accepts a word when a pop frees a slot on the same edge;
  // the slot being written is the one being read, so the read sees old data.
  assign push = in_tvalid & ((count_q < DEPTH_C) | pop);
  assign drop = in_tvalid & ~push;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    fd_d     = 1'b0;
    fw_d     = fw_q;
    wcnt_d   = wcnt_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    end

    if (push && !pop) begin
      count_d = count_q + (ADDR_W+1)'(1);
    end else if (pop && !push) begin
      count_d = count_q - (ADDR_W+1)'(1);
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    // Frame accounting is driven purely by the output side so that dropped
    // words never contribute to the count.
    if (pop) begin
      if (out_tlast) begin
        fw_d   = wcnt_q + CNT_W'(1);
        fd_d   = 1'b1;
        wcnt_d = '0;
      end else begin
        wcnt_d = wcnt_q + CNT_W'(1);
      end
    end

    // Registered from the next occupancy so it reflects the post-edge level
    af_d = (count_d >= AF_LVL_C);
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      fd_q     <= 1'b0;
      fw_q     <= '0;
      wcnt_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      af_q     <= af_d;
      ovf_q    <= ovf_d;
      fd_q     <= fd_d;
      fw_q     <= fw_d;
      wcnt_q   <= wcnt_d;
    end
  end

  // Memory contents need no reset; occupancy gates their visibility
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_tlast, in_tdata};
    end
  end

  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign frame_done  = fd_q;
  assign frame_words = fw_q;

endmodule
`default_nettype wire

// File: tb/tb_ccsds123_out_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ccsds123_out_buffer
//  Purpose  : Self-checking bench for ccsds123_out_buffer. A queue-based model
//             of the FIFO and frame accounting is compared with the DUT on
//             every falling clock edge; directed scenarios add literal checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_ccsds123_out_buffer;

  localparam int DEPTH = 16;
  localparam int AFL   = 12;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic [63:0] in_tdata = '0;
  logic        in_tvalid = 1'b0;
  logic        in_tlast = 1'b0;
  logic [63:0] out_tdata;
  logic        out_tvalid;
  logic        out_tready = 1'b0;
  logic        out_tlast;
  logic        almost_full;
  logic        overflow;
  logic        frame_done;
  logic [31:0] frame_words;

  ccsds123_out_buffer #(
    .BUS_WIDTH(64), .ADDR_W(4), .HEADROOM(4), .CNT_W(32)
  ) dut (
    .clk(clk), .aresetn(aresetn),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tlast(in_tlast),
    .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tlast(out_tlast), .almost_full(almost_full), .overflow(overflow),
    .frame_done(frame_done), .frame_words(frame_words)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [64:0] mq[$];
  int          cnt_m = 0;
  logic        e_af = 1'b0, e_ovf = 1'b0, e_fd = 1'b0;
  logic [31:0] e_fw = '0;

  // Observations
  int obs_fw[$];
  int pops_seen = 0;
  bit dead_seen = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the buffer must hold after each clock edge
  initial begin
    bit p, w;
    logic [64:0] h;
    forever begin
      @(posedge clk or negedge aresetn);
      if (!aresetn) begin
        mq.delete();
        cnt_m = 0; e_af = 0; e_ovf = 0; e_fd = 0; e_fw = '0;
      end else begin
        p = (mq.size() != 0) && out_tready;
        w = in_tvalid && ((mq.size() < DEPTH) || p);
        e_fd = 0;
        if (p) begin
          h = mq.pop_front();
          cnt_m++;
          if (h[64]) begin
            e_fw = cnt_m; e_fd = 1; cnt_m = 0;
          end
        end
        if (w) mq.push_back({in_tlast, in_tdata});
        if (in_tvalid && !w) e_ovf = 1;
        e_af = (mq.size() >= AFL);
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      if (aresetn) begin
        chk("tvalid", out_tvalid, mq.size() != 0);
        if (mq.size() != 0) begin
          chk("tdata", out_tdata, mq[0][63:0]);
          chk("tlast", out_tlast, mq[0][64]);
          if (out_tready) begin
            pops_seen++;
            if (out_tdata == 64'hDEAD) dead_seen = 1;
          end
        end
        chk("almost_full", almost_full, e_af);
        chk("overflow", overflow, e_ovf);
        chk("frame_done", frame_done, e_fd);
        chk("frame_words", frame_words, e_fw);
        if (frame_done) obs_fw.push_back(int'(frame_words));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic l);
    in_tvalid = 1; in_tdata = d; in_tlast = l;
    tick();
    in_tvalid = 0; in_tlast = 0;
  endtask

  task automatic drain(input int n);
    out_tready = 1;
    repeat (n) tick();
    chk("drained_empty", out_tvalid, 0);
  endtask

  task automatic apply_reset();
    aresetn = 0; in_tvalid = 0; in_tlast = 0; out_tready = 0;
    repeat (2) tick();
    chk("rst_tvalid", out_tvalid, 0);
    chk("rst_af", almost_full, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_fw", frame_words, 0);
    aresetn = 1;
    obs_fw.delete(); pops_seen = 0; dead_seen = 0;
    tick();
  endtask

  function automatic int fw_at(input int i);
    return (obs_fw.size() > i) ? obs_fw[i] : -1;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    // Pass-through
    apply_reset();
    out_tready = 1;
    for (int i = 1; i <= 10; i++) send(64'(i), i == 10);
    drain(5);
    chk("pt_frames", obs_fw.size(), 1);
    chk("pt_fw", fw_at(0), 10);
    chk("pt_ovf", overflow, 0);

    // Backpressure fill, then overflow
    apply_reset();
    out_tready = 0;
    for (int i = 1; i <= 11; i++) send(64'(i), 0);
    chk("af_at_11", almost_full, 0);
    send(64'd12, 0);
    chk("af_at_12", almost_full, 1);
    for (int i = 13; i <= 16; i++) send(64'(i), i == 16);
    chk("full_no_ovf", overflow, 0);
    chk("full_valid", out_tvalid, 1);
    send(64'hDEAD, 0);
    chk("ovf_set", overflow, 1);
    drain(20);
    chk("ovf_sticky", overflow, 1);
    chk("ovf_pops", pops_seen, 16);
    chk("dead_absent", dead_seen, 0);
    chk("ovf_fw", fw_at(0), 16);

    // Full with simultaneous pop and push across pointer wrap
    apply_reset();
    out_tready = 0;
    for (int i = 1; i <= 16; i++) send(64'(i), 0);
    out_tready = 1;
    for (int k = 0; k < 5; k++) send(64'(100 + k), k == 4);
    chk("fpp_ovf", overflow, 0);
    chk("fpp_af", almost_full, 1);
    chk("fpp_valid", out_tvalid, 1);
    drain(20);
    chk("fpp_pops", pops_seen, 21);
    chk("fpp_fw", fw_at(0), 21);

    // Random ready, back-to-back frames of 7 and 20 words
    apply_reset();
    sent = 0; guard = 0;
    while (sent < 27 && guard < 2000) begin
      out_tready = $urandom_range(1, 0) == 1;
      if (!almost_full && ($urandom_range(3, 0) != 0)) begin
        in_tvalid = 1;
        in_tdata  = {$urandom, $urandom};
        in_tlast  = (sent == 6) || (sent == 26);
        sent++;
      end else begin
        in_tvalid = 0; in_tlast = 0;
      end
      tick();
      guard++;
    end
    in_tvalid = 0; in_tlast = 0;
    chk("rnd_stim_done", sent, 27);
    guard = 0;
    while (out_tvalid && guard < 1000) begin
      out_tready = $urandom_range(1, 0) == 1;
      tick();
      guard++;
    end
    drain(3);
    chk("rnd_ovf", overflow, 0);
    chk("rnd_frames", obs_fw.size(), 2);
    chk("rnd_fw0", fw_at(0), 7);
    chk("rnd_fw1", fw_at(1), 20);

    // Reset mid-frame, asserted between clock edges
    apply_reset();
    out_tready = 0;
    for (int i = 1; i <= 5; i++) send(64'(200 + i), 0);
    chk("mid_valid_before", out_tvalid, 1);
    #3;
    aresetn = 0;
    #1;
    chk("mid_async_clear", out_tvalid, 0);
    tick();
    tick();
    #2;
    aresetn = 1;
    obs_fw.delete();
    tick();
    chk("mid_empty_after", out_tvalid, 0);
    out_tready = 1;
    for (int i = 1; i <= 3; i++) send(64'(300 + i), i == 3);
    drain(5);
    chk("mid_frames", obs_fw.size(), 1);
    chk("mid_fw", fw_at(0), 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ccsds123_out_buffer.md
Name: ccsds123_out_buffer

Overview:
- Receiver for the compressed-output bus of ccsds123_top. That bus is valid-only: out_tdata/out_tvalid/out_tlast, with no ready.
- Captures every valid word into a FIFO and re-emits it as a full AXI-Stream master with tready, so downstream DMA/AXI logic can apply backpressure.
- Provides an almost-full signal the integrator gates into the core's in_tvalid to throttle sample input.
- Provides a sticky overflow flag and per-frame word accounting.

Parameters:
- BUS_WIDTH, 64, data width of the core output bus; multiple of 8.
- ADDR_W, 4, FIFO address width; DEPTH = 2**ADDR_W entries.
- HEADROOM, 4, almost_full asserts when occupancy >= DEPTH-HEADROOM; must satisfy 1 <= HEADROOM < DEPTH; covers the core pipeline drain.
- CNT_W, 32, width of frame word counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- aresetn  in  1  asynchronous active-low reset
- in_tdata  in  BUS_WIDTH  word from ccsds123_top out_tdata
- in_tvalid  in  1  word valid; no ready, word must be captured or counted as lost
- in_tlast  in  1  last word of compressed image
- out_tdata  out  BUS_WIDTH  AXI-Stream data
- out_tvalid  out  1  AXI-Stream valid
- out_tready  in  1  AXI-Stream ready
- out_tlast  out  1  AXI-Stream last
- almost_full  out  1  occupancy >= DEPTH-HEADROOM
- overflow  out  1  sticky: a valid input word was dropped
- frame_done  out  1  one-cycle pulse after the tlast word is transferred on the output
- frame_words  out  CNT_W  number of words in the frame just completed; valid when frame_done=1, held until the next frame_done

Behaviour:
- Reset (aresetn=0, asynchronous): occupancy=0, write/read pointers=0, out_tvalid=0, almost_full=0, overflow=0, frame_done=0, frame_words=0, internal word counter=0. Memory contents are don't-care.
- Reset mid-frame discards all buffered words. After release, the next word is treated as word 1 of a new frame.
- Storage: DEPTH entries of {tlast, tdata}, with circular pointers of ADDR_W bits that wrap DEPTH-1 -> 0. Occupancy counter is ADDR_W+1 bits, range 0..DEPTH.
- Output is first-word-fall-through:
  - out_tvalid = (occupancy != 0).
  - out_tdata/out_tlast = entry at the read pointer.
  - A word written on edge N is visible with out_tvalid=1 after edge N (latency 1 cycle).
- pop = out_tvalid & out_tready. On pop, the read pointer advances.
- out_tdata/out_tlast stay stable while out_tvalid=1 and out_tready=0 (AXI rule).
- push = in_tvalid & (occupancy < DEPTH | pop). A full FIFO accepts a write in the same cycle as a pop; occupancy stays DEPTH.
- in_tvalid=1 while occupancy==DEPTH and no pop:
  - word dropped, pointers unchanged;
  - overflow <= 1, cleared only by reset.
- Occupancy next value:
  - +1 on push without pop;
  - -1 on pop without push;
  - unchanged on both or neither.
- almost_full is registered from the next occupancy value, so it reflects occupancy after the current edge.
- Frame accounting:
  - Word counter increments on each pop.
  - On a pop with out_tlast=1: frame_words <= counter+1, frame_done <= 1 for exactly one cycle, counter <= 0.
- Dropped words are not counted in frame_words. A dropped tlast word still ends the frame only via overflow; no frame_done is produced.
- in_tlast is carried per word; there is no separate frame state machine on the input side.
- Back-to-back frames: the tlast of frame A and word 1 of frame B may be in the FIFO together. Counting restarts at B's first pop.

Test Plan:
- Pass-through: out_tready=1, push 10 words with values 1..10, tlast on word 10 -> out_tvalid one cycle after each push, same data and order; frame_done pulses once with frame_words=10; overflow=0.
- Backpressure fill (DEPTH=16, HEADROOM=4): out_tready=0, push 12 words -> almost_full=1 after the 12th push edge and 0 after 11 pushes. Push 4 more -> occupancy 16, no overflow. Then out_tready=1 -> 16 words emitted in order.
- Overflow: FIFO full, out_tready=0, push 1 word 0xDEAD -> overflow=1 and sticks; 0xDEAD never appears on the output; the other 16 words drain intact.
- Full with simultaneous pop and push: occupancy 16, out_tready=1 and in_tvalid=1 for 5 cycles -> no overflow, occupancy stays 16, output order preserved across pointer wrap.
- Random out_tready (~50%) with two back-to-back frames of 7 and 20 words -> data matches a reference queue, no drops; frame_done pulses twice with frame_words 7 then 20.
- Reset mid-frame: after 5 words are buffered, pulse aresetn low asynchronously (not on an edge) -> out_tvalid=0 immediately. After release, a 3-word frame yields frame_words=3.
